axi_boot_loader: RTL and testbench
==================================

// Module: axi_boot_loader
// PURPOSE
//  AXI4 write-only master that loads a program image into the shared RAM over a byte stream
//  (UART RX side) while holding the core in reset. It then releases the core.
//  Sits as an extra master port on the memory crossbar, beside the core's instr/data masters.
//  It sequences stream framing, word packing, AXI write issue and checksum check, in that order.
// PARAMETERS
//  AXI_ADDR_WIDTH  32   address width; only 32 is supported
//  AXI_DATA_WIDTH  32   data width; only 32 is supported (4 byte lanes)
//  AXI_ID_WIDTH    16   width of aw_id_o
//  AXI_USER_WIDTH  10   width of aw_user_o/w_user_o, both driven to 0
//  BOOT_ID         0    constant value driven on aw_id_o
//  MAGIC           8'hB0  frame start byte
// PORTS
//  clk_i        in   1    clock
//  rst_ni       in   1    asynchronous active-low reset
//  bypass_i     in   1    1: skip loading and release the core immediately
//  rx_valid_i   in   1    stream byte valid
//  rx_data_i    in   8    stream byte
//  rx_ready_o   out  1    stream byte accepted when rx_valid_i && rx_ready_o
//  aw_valid_o   out  1    AW valid
//  aw_ready_i   in   1    AW ready
//  aw_addr_o    out  32   word address; aw_len=0, aw_size=2, aw_burst=INCR, all constant
//  aw_id_o      out  ID   BOOT_ID
//  aw_user_o    out  USER 0
//  w_valid_o    out  1    W valid
//  w_ready_i    in   1    W ready
//  w_data_o     out  32   packed data word
//  w_strb_o     out  4    byte strobes
//  w_last_o     out  1    constant 1
//  w_user_o     out  USER 0
//  b_valid_i    in   1    B valid
//  b_resp_i     in   2    B response
//  b_ready_o    out  1    B ready
//  core_rst_no  out  1    core reset, active low
//  boot_done_o  out  1    image loaded and verified
//  boot_err_o   out  1    load failed (sticky until reset)
// BEHAVIOUR
//  Reset values: all outputs are 0 (core held in reset). The FSM is in IDLE.
//  Frame format: MAGIC, ADDR[4] (little-endian), LEN[4] (little-endian, bytes), LEN payload bytes, CSUM.
//    CSUM = XOR of all payload bytes.
//  States and transitions:
//    IDLE: entered on the first clock after reset release.
//      If bypass_i=1 -> DONE.
//      Otherwise rx_ready_o=1. A byte equal to MAGIC -> ADDR. Any other byte is silently dropped.
//    ADDR: accept 4 bytes.
//      If ADDR[1:0]!=0 -> ERR.
//      Otherwise LEN.
//    LEN: accept 4 bytes.
//      If LEN==0 -> CSUM.
//      Otherwise DATA.
//    DATA: pack bytes into lane = byte index mod 4. Go to WR after the 4th byte or after the final payload byte.
//      Unused lanes are 0. strb = 4'hF for full words; for a partial last word, strb = (1<<(LEN%4))-1.
//      The running XOR is updated on each accepted byte.
//    WR: rx_ready_o=0. aw_valid_o and w_valid_o assert in the first WR cycle.
//      Each channel drops independently once its handshake completes. When both are done -> BRSP.
//      The AW and W handshakes may occur in either order or in the same cycle.
//    BRSP: b_ready_o=1. On b_valid_i:
//      resp!=OKAY -> ERR.
//      Otherwise, if bytes remain -> DATA and the address advances by 4 (32-bit wrap-around, no error). Else -> CSUM.
//    CSUM: accept 1 byte.
//      Equal to the running XOR -> DONE.
//      Otherwise -> ERR.
//    DONE (terminal): core_rst_no=1, boot_done_o=1.
//    ERR (terminal): boot_err_o=1, core_rst_no stays 0.
//  Exactly one write is outstanding at a time. Stream backpressure: rx_ready_o=0 outside IDLE/ADDR/LEN/DATA/CSUM.
//  Latency: aw_valid_o/w_valid_o rise 1 cycle after the 4th byte of a word is accepted.
//  Registers: the 32-bit byte counter decrements on each payload byte. The address register is 32 bits.
//  AXI stability: aw_addr_o, w_data_o and w_strb_o are held stable while the corresponding valid is high.
//  Valid never drops before its handshake completes.
//  bypass_i is sampled only in IDLE. Once the FSM leaves IDLE, bypass_i is ignored.
//  Reset mid-operation (any state): immediate return to reset values.
//    An in-flight AXI transaction is abandoned; the interconnect is reset together with this block.
// TESTING
//  T1: bypass_i=1 at reset release -> core_rst_no=1, boot_done_o=1 one cycle after leaving IDLE; no AW.
//  T2: frame B0, addr 0x100, LEN 8, bytes 01..08, CSUM 0x08 ->
//      two writes: 0x100 <- 0x04030201 with strb F, then 0x104 <- 0x08070605 with strb F; then DONE.
//  T3: LEN 5, payload AA BB CC DD EE ->
//      second write 0x000000EE with strb 4'h1; correct CSUM -> DONE.
//  T4: random aw_ready_i/w_ready_i/b_valid_i stalls, including W accepted before AW ->
//      identical write sequence and stable payloads while valid is high.
//  T5: b_resp_i=SLVERR on the first write -> ERR, boot_err_o=1, core_rst_no=0, rx_ready_o=0 thereafter.
//  T6: wrong CSUM -> ERR.
//      Also: ADDR 0x102 -> ERR.
//      Also: garbage bytes 00 FF before B0 -> dropped, frame loads normally.
//      Also: rst_ni pulsed mid-DATA -> outputs return to 0 and a new frame loads correctly.

Source files
------------

// File: rtl/axi_boot_loader.sv
// AXI4 write-only boot master: receives a framed program image over a byte
// stream, writes it word by word into shared RAM, verifies an XOR checksum
// and then releases the core from reset.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | reset just released, no byte accepted yet
// IDLE  | hunting for the MAGIC start byte (or taking the bypass path)
// ADDR  | collecting the 4-byte little-endian start address
// LEN   | collecting the 4-byte little-endian payload length
// DATA  | packing payload bytes into the current write word
// WR    | AW and W channels presented, waiting for both handshakes
// BRSP  | waiting for the write response
// CSUM  | collecting the trailing checksum byte
// DONE  | image loaded and verified, core released (terminal)
// ERR   | load failed, core stays in reset (terminal)

module axi_boot_loader #(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          AXI_ID_WIDTH   = 16,
    parameter int          AXI_USER_WIDTH = 10,
    parameter int          BOOT_ID        = 0,
    parameter logic [7:0]  MAGIC          = 8'hB0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        bypass_i,
    input  logic                        rx_valid_i,
    input  logic [7:0]                  rx_data_i,
    output logic                        rx_ready_o,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
    output logic [AXI_USER_WIDTH-1:0]   aw_user_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic                        w_last_o,
    output logic [AXI_USER_WIDTH-1:0]   w_user_o,
    input  logic                        b_valid_i,
    input  logic [1:0]                  b_resp_i,
    output logic                        b_ready_o,
    output logic                        core_rst_no,
    output logic                        boot_done_o,
    output logic                        boot_err_o
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_ADDR, S_LEN, S_DATA, S_WR, S_BRSP, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t                    state;
    logic [1:0]                byte_idx;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               len_q;
    logic [AXI_DATA_WIDTH-1:0] data_q;
    logic [STRB_WIDTH-1:0]     strb_q;
    logic [7:0]                csum_q;
    logic                      accept;
    logic                      aw_done;
    logic                      w_done;

    assign accept  = rx_valid_i && rx_ready_o;
    assign aw_done = !aw_valid_o || aw_ready_i;
    assign w_done  = !w_valid_o || w_ready_i;

    // Single-beat INCR writes with fixed ID and zero user bits.
    assign aw_addr_o = addr_q;
    assign aw_id_o   = AXI_ID_WIDTH'(BOOT_ID);
    assign aw_user_o = '0;
    assign w_data_o  = data_q;
    assign w_strb_o  = strb_q;
    assign w_last_o  = 1'b1;
    assign w_user_o  = '0;

    // Boot sequencer: framing, word packing, write issue and checksum check.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_INIT;
            byte_idx    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            csum_q      <= '0;
            rx_ready_o  <= 1'b0;
            aw_valid_o  <= 1'b0;
            w_valid_o   <= 1'b0;
            b_ready_o   <= 1'b0;
            core_rst_no <= 1'b0;
            boot_done_o <= 1'b0;
            boot_err_o  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    state      <= S_IDLE;
                    rx_ready_o <= 1'b1;
                end
                S_IDLE: begin
                    if (bypass_i) begin
                        state       <= S_DONE;
                        rx_ready_o  <= 1'b0;
                        core_rst_no <= 1'b1;
                        boot_done_o <= 1'b1;
                    end else if (accept && rx_data_i == MAGIC) begin
                        state    <= S_ADDR;
                        byte_idx <= '0;
                        csum_q   <= '0;
                    end
                end
                S_ADDR: begin
                    if (accept) begin
                        addr_q[{byte_idx, 3'b000} +: 8] <= rx_data_i;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // byte 0 is already captured, so the alignment check is valid here
                            if (addr_q[1:0] != 2'b00) begin
                                state      <= S_ERR;
                                rx_ready_o <= 1'b0;
                                boot_err_o <= 1'b1;
                            end else begin
                                state <= S_LEN;
                            end
                        end
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        len_q[{byte_idx, 3'b000} +: 8] <= rx_data_i;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            data_q <= '0;
                            strb_q <= '0;
                            if ({rx_data_i, len_q[23:0]} == 32'd0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        // strobes accumulate lane by lane, giving (1<<n)-1 on a short tail
                        data_q[{byte_idx, 3'b000} +: 8] <= rx_data_i;
                        strb_q[byte_idx] <= 1'b1;
                        csum_q           <= csum_q ^ rx_data_i;
                        len_q            <= len_q - 32'd1;
                        byte_idx         <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3 || len_q == 32'd1) begin
                            state      <= S_WR;
                            rx_ready_o <= 1'b0;
                            aw_valid_o <= 1'b1;
                            w_valid_o  <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (aw_valid_o && aw_ready_i) aw_valid_o <= 1'b0;
                    if (w_valid_o && w_ready_i)   w_valid_o  <= 1'b0;
                    if (aw_done && w_done) begin
                        state     <= S_BRSP;
                        b_ready_o <= 1'b1;
                    end
                end
                S_BRSP: begin
                    if (b_valid_i) begin
                        b_ready_o <= 1'b0;
                        if (b_resp_i != 2'b00) begin
                            state      <= S_ERR;
                            boot_err_o <= 1'b1;
                        end else if (len_q != 32'd0) begin
                            state      <= S_DATA;
                            addr_q     <= addr_q + AXI_ADDR_WIDTH'(4);
                            byte_idx   <= '0;
                            data_q     <= '0;
                            strb_q     <= '0;
                            rx_ready_o <= 1'b1;
                        end else begin
                            state      <= S_CSUM;
                            rx_ready_o <= 1'b1;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        rx_ready_o <= 1'b0;
                        if (rx_data_i == csum_q) begin
                            state       <= S_DONE;
                            core_rst_no <= 1'b1;
                            boot_done_o <= 1'b1;
                        end else begin
                            state      <= S_ERR;
                            boot_err_o <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_boot_loader.sv
// Directed bench for axi_boot_loader with a small AXI slave responder.
module tb_axi_boot_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        bypass_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_ready_o;
    logic        aw_valid_o;
    logic        aw_ready_i;
    logic [31:0] aw_addr_o;
    logic [15:0] aw_id_o;
    logic [9:0]  aw_user_o;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        w_last_o;
    logic [9:0]  w_user_o;
    logic        b_valid_i;
    logic [1:0]  b_resp_i;
    logic        b_ready_o;
    logic        core_rst_no;
    logic        boot_done_o;
    logic        boot_err_o;

    axi_boot_loader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bypass_i(bypass_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_id_o(aw_id_o), .aw_user_o(aw_user_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
        .b_valid_i(b_valid_i), .b_resp_i(b_resp_i), .b_ready_o(b_ready_o),
        .core_rst_no(core_rst_no), .boot_done_o(boot_done_o), .boot_err_o(boot_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          passed = 0;
    int          stab_err = 0;
    int          slave_mode = 0;   // 0: always ready, 1: random stalls, 2: W before AW
    bit          resp_err = 1'b0;
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [3:0]  cap_strb[$];
    logic [7:0]  pay[$];
    bit          aw_got, w_got, b_done_next, aw_hold, w_hold;
    logic [31:0] hold_addr, hold_data;
    logic [3:0]  hold_strb;

    // AXI slave: decides readies/response at the falling edge, records handshakes
    // that will complete at the next rising edge, and checks payload stability.
    initial begin
        aw_ready_i = 1'b0; w_ready_i = 1'b0; b_valid_i = 1'b0; b_resp_i = 2'b00;
        aw_got = 0; w_got = 0; b_done_next = 0; aw_hold = 0; w_hold = 0;
        hold_addr = '0; hold_data = '0; hold_strb = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                aw_ready_i = 1'b0; w_ready_i = 1'b0; b_valid_i = 1'b0;
                aw_got = 0; w_got = 0; b_done_next = 0; aw_hold = 0; w_hold = 0;
            end else begin
                if (b_done_next) begin
                    b_valid_i = 1'b0; b_done_next = 0; aw_got = 0; w_got = 0;
                end
                if (aw_hold && (aw_valid_o !== 1'b1 || aw_addr_o !== hold_addr)) stab_err++;
                if (w_hold && (w_valid_o !== 1'b1 || w_data_o !== hold_data || w_strb_o !== hold_strb)) stab_err++;
                if (aw_got && w_got && !b_valid_i) begin
                    b_valid_i = (slave_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                    b_resp_i  = resp_err ? 2'b10 : 2'b00;
                end
                case (slave_mode)
                    0: begin aw_ready_i = 1'b1; w_ready_i = 1'b1; end
                    1: begin aw_ready_i = 1'($urandom_range(0, 1)); w_ready_i = 1'($urandom_range(0, 1)); end
                    default: begin aw_ready_i = w_got; w_ready_i = 1'b1; end
                endcase
                if (aw_valid_o && aw_ready_i) begin
                    cap_addr.push_back(aw_addr_o); aw_got = 1; aw_hold = 0;
                    if (aw_id_o !== 16'h0 || aw_user_o !== 10'h0) stab_err++;
                end else begin
                    aw_hold = aw_valid_o; hold_addr = aw_addr_o;
                end
                if (w_valid_o && w_ready_i) begin
                    cap_data.push_back(w_data_o); cap_strb.push_back(w_strb_o); w_got = 1; w_hold = 0;
                    if (w_last_o !== 1'b1 || w_user_o !== 10'h0) stab_err++;
                end else begin
                    w_hold = w_valid_o; hold_data = w_data_o; hold_strb = w_strb_o;
                end
                if (b_valid_i && b_ready_o) b_done_next = 1;
            end
        end
    end

    task automatic do_reset(input bit byp);
        rst_ni = 1'b0; rx_valid_i = 1'b0; bypass_i = byp; resp_err = 1'b0;
        repeat (3) @(negedge clk_i);
        cap_addr.delete(); cap_data.delete(); cap_strb.delete();
        stab_err = 0;
        rst_ni = 1'b1;
    endtask

    // Offers one byte; skips it if the loader has already terminated.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid_i = 1'b1; rx_data_i = b;
        while (!rx_ready_o && !boot_err_o && !boot_done_o && n < 300) begin
            @(negedge clk_i); n++;
        end
        if (n >= 300) begin
            total++; $display("FAIL rx_timeout: byte %h never accepted, required acceptance", b);
        end
        if (rx_ready_o) @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [7:0] cs);
        logic [31:0] l = 32'(pay.size());
        send_byte(8'hB0);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
        for (int i = 0; i < pay.size(); i++) send_byte(pay[i]);
        send_byte(cs);
    endtask

    task automatic wait_end;
        int n = 0;
        while (!boot_done_o && !boot_err_o && n < 2000) begin
            @(negedge clk_i); n++;
        end
        if (n >= 2000) begin
            total++; $display("FAIL end_timeout: done=%b err=%b, required one of them high", boot_done_o, boot_err_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        @(negedge clk_i);
        total++; if (rx_ready_o !== 1'b0) $display("FAIL rst_rx_ready: got %b want 0", rx_ready_o); else passed++;
        total++; if (aw_valid_o !== 1'b0) $display("FAIL rst_aw_valid: got %b want 0", aw_valid_o); else passed++;
        total++; if (w_valid_o !== 1'b0) $display("FAIL rst_w_valid: got %b want 0", w_valid_o); else passed++;
        total++; if (b_ready_o !== 1'b0) $display("FAIL rst_b_ready: got %b want 0", b_ready_o); else passed++;
        total++; if (core_rst_no !== 1'b0) $display("FAIL rst_core: got %b want 0", core_rst_no); else passed++;
        total++; if (boot_done_o !== 1'b0) $display("FAIL rst_done: got %b want 0", boot_done_o); else passed++;
        total++; if (boot_err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", boot_err_o); else passed++;
        total++; if (aw_addr_o !== 32'h0) $display("FAIL rst_addr: got %h want 0", aw_addr_o); else passed++;
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        total++; if (rx_ready_o !== 1'b1) $display("FAIL idle_rx_ready: got %b want 1", rx_ready_o); else passed++;
    endtask

    task automatic test_bypass;
        do_reset(1'b1);
        @(negedge clk_i);
        total++; if (core_rst_no !== 1'b0) $display("FAIL byp_early_core: got %b want 0", core_rst_no); else passed++;
        repeat (3) @(negedge clk_i);
        bypass_i = 1'b0;
        repeat (2) @(negedge clk_i);
        total++; if (core_rst_no !== 1'b1) $display("FAIL byp_core: got %b want 1", core_rst_no); else passed++;
        total++; if (boot_done_o !== 1'b1) $display("FAIL byp_done: got %b want 1", boot_done_o); else passed++;
        total++; if (boot_err_o !== 1'b0) $display("FAIL byp_err: got %b want 0", boot_err_o); else passed++;
        total++; if (rx_ready_o !== 1'b0) $display("FAIL byp_rx_ready: got %b want 0", rx_ready_o); else passed++;
        total++; if (cap_addr.size() !== 0) $display("FAIL byp_no_aw: got %0d writes want 0", cap_addr.size()); else passed++;
    endtask

    task automatic test_basic;
        logic [31:0] ea[2] = '{32'h100, 32'h104};
        logic [31:0] ed[2] = '{32'h04030201, 32'h08070605};
        do_reset(1'b0); slave_mode = 0;
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(32'h100, 8'h08);
        wait_end();
        total++; if (cap_addr.size() !== 2 || cap_data.size() !== 2) $display("FAIL basic_count: got %0d/%0d want 2", cap_addr.size(), cap_data.size()); else passed++;
        for (int i = 0; i < 2 && i < cap_addr.size() && i < cap_data.size(); i++) begin
            total++; if (cap_addr[i] !== ea[i]) $display("FAIL basic_addr%0d: got %h want %h", i, cap_addr[i], ea[i]); else passed++;
            total++; if (cap_data[i] !== ed[i]) $display("FAIL basic_data%0d: got %h want %h", i, cap_data[i], ed[i]); else passed++;
            total++; if (cap_strb[i] !== 4'hF) $display("FAIL basic_strb%0d: got %h want f", i, cap_strb[i]); else passed++;
        end
        total++; if (boot_done_o !== 1'b1 || core_rst_no !== 1'b1 || boot_err_o !== 1'b0) $display("FAIL basic_done: got done=%b core=%b err=%b want 1 1 0", boot_done_o, core_rst_no, boot_err_o); else passed++;
        total++; if (stab_err !== 0) $display("FAIL basic_stable: got %0d violations want 0", stab_err); else passed++;
    endtask

    task automatic test_partial;
        do_reset(1'b0); slave_mode = 0;
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_frame(32'h200, 8'hEE);
        wait_end();
        total++; if (cap_data.size() !== 2) $display("FAIL part_count: got %0d want 2", cap_data.size()); else passed++;
        if (cap_data.size() == 2 && cap_addr.size() == 2) begin
            total++; if (cap_data[0] !== 32'hDDCCBBAA) $display("FAIL part_data0: got %h want ddccbbaa", cap_data[0]); else passed++;
            total++; if (cap_addr[1] !== 32'h204) $display("FAIL part_addr1: got %h want 00000204", cap_addr[1]); else passed++;
            total++; if (cap_data[1] !== 32'h000000EE) $display("FAIL part_data1: got %h want 000000ee", cap_data[1]); else passed++;
            total++; if (cap_strb[1] !== 4'h1) $display("FAIL part_strb1: got %h want 1", cap_strb[1]); else passed++;
        end
        total++; if (boot_done_o !== 1'b1) $display("FAIL part_done: got %b want 1", boot_done_o); else passed++;
    endtask

    task automatic test_stalls;
        // W accepted before AW on every write
        do_reset(1'b0); slave_mode = 2;
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(32'h300, 8'h08);
        wait_end();
        total++; if (cap_addr.size() !== 2 || cap_addr[1] !== 32'h304 || cap_data[1] !== 32'h08070605) $display("FAIL wfirst_seq: got %0d writes, last %h<-%h want 304<-08070605", cap_addr.size(), cap_addr[cap_addr.size()-1], cap_data[cap_data.size()-1]); else passed++;
        total++; if (stab_err !== 0 || boot_done_o !== 1'b1) $display("FAIL wfirst_stable: got viol=%0d done=%b want 0 1", stab_err, boot_done_o); else passed++;
        // random stalls on AW, W and B, 7-byte payload
        do_reset(1'b0); slave_mode = 1;
        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_frame(32'h400, 8'h00);
        wait_end();
        total++; if (cap_addr.size() !== 2 || cap_data.size() !== 2) $display("FAIL rand_count: got %0d/%0d want 2", cap_addr.size(), cap_data.size()); else passed++;
        if (cap_addr.size() == 2 && cap_data.size() == 2) begin
            total++; if (cap_addr[0] !== 32'h400 || cap_data[0] !== 32'h44332211 || cap_strb[0] !== 4'hF) $display("FAIL rand_w0: got %h<-%h/%h want 400<-44332211/f", cap_addr[0], cap_data[0], cap_strb[0]); else passed++;
            total++; if (cap_addr[1] !== 32'h404 || cap_data[1] !== 32'h00776655 || cap_strb[1] !== 4'h7) $display("FAIL rand_w1: got %h<-%h/%h want 404<-00776655/7", cap_addr[1], cap_data[1], cap_strb[1]); else passed++;
        end
        total++; if (stab_err !== 0 || boot_done_o !== 1'b1) $display("FAIL rand_stable: got viol=%0d done=%b want 0 1", stab_err, boot_done_o); else passed++;
        slave_mode = 0;
    endtask

    task automatic test_boundaries;
        // zero-length image: checksum of nothing is 0
        do_reset(1'b0);
        pay.delete();
        send_frame(32'h800, 8'h00);
        wait_end();
        total++; if (boot_done_o !== 1'b1 || cap_addr.size() !== 0) $display("FAIL len0: got done=%b writes=%0d want 1 0", boot_done_o, cap_addr.size()); else passed++;
        // address wraps past the top of the space
        do_reset(1'b0);
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(32'hFFFF_FFFC, 8'h08);
        wait_end();
        total++; if (cap_addr.size() !== 2 || cap_addr[0] !== 32'hFFFF_FFFC || cap_addr[1] !== 32'h0) $display("FAIL wrap_addr: got %0d writes, last %h want fffffffc,00000000", cap_addr.size(), cap_addr[cap_addr.size()-1]); else passed++;
        total++; if (boot_done_o !== 1'b1 || boot_err_o !== 1'b0) $display("FAIL wrap_done: got done=%b err=%b want 1 0", boot_done_o, boot_err_o); else passed++;
    endtask

    task automatic test_errors;
        // SLVERR on the first write
        do_reset(1'b0); resp_err = 1'b1;
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(32'h100, 8'h08);
        wait_end();
        repeat (5) @(negedge clk_i);
        total++; if (boot_err_o !== 1'b1 || core_rst_no !== 1'b0 || boot_done_o !== 1'b0) $display("FAIL slverr_flags: got err=%b core=%b done=%b want 1 0 0", boot_err_o, core_rst_no, boot_done_o); else passed++;
        total++; if (rx_ready_o !== 1'b0) $display("FAIL slverr_rx_ready: got %b want 0", rx_ready_o); else passed++;
        total++; if (cap_addr.size() !== 1) $display("FAIL slverr_count: got %0d want 1", cap_addr.size()); else passed++;
        // wrong checksum
        do_reset(1'b0);
        send_frame(32'h100, 8'h09);
        wait_end();
        total++; if (boot_err_o !== 1'b1 || boot_done_o !== 1'b0 || cap_addr.size() !== 2) $display("FAIL badcsum: got err=%b done=%b writes=%0d want 1 0 2", boot_err_o, boot_done_o, cap_addr.size()); else passed++;
        // misaligned start address
        do_reset(1'b0);
        send_frame(32'h102, 8'h08);
        wait_end();
        total++; if (boot_err_o !== 1'b1 || core_rst_no !== 1'b0 || cap_addr.size() !== 0) $display("FAIL misalign: got err=%b core=%b writes=%0d want 1 0 0", boot_err_o, core_rst_no, cap_addr.size()); else passed++;
    endtask

    task automatic test_garbage_and_reset;
        do_reset(1'b0);
        send_byte(8'h00);
        send_byte(8'hFF);
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_frame(32'h600, 8'hEE);
        wait_end();
        total++; if (boot_done_o !== 1'b1 || cap_addr.size() !== 2 || cap_data[0] !== 32'hDDCCBBAA) $display("FAIL garbage: got done=%b writes=%0d want 1 2 first ddccbbaa", boot_done_o, cap_addr.size()); else passed++;
        // reset pulsed while the DATA word is half-packed
        do_reset(1'b0);
        send_byte(8'hB0);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        rst_ni = 1'b0;
        #1;
        total++; if (rx_ready_o !== 1'b0 || aw_valid_o !== 1'b0 || w_valid_o !== 1'b0 || core_rst_no !== 1'b0 || boot_done_o !== 1'b0 || boot_err_o !== 1'b0) $display("FAIL midreset_outs: got rdy=%b aw=%b w=%b core=%b done=%b err=%b want all 0", rx_ready_o, aw_valid_o, w_valid_o, core_rst_no, boot_done_o, boot_err_o); else passed++;
        @(negedge clk_i);
        do_reset(1'b0);
        send_frame(32'h500, 8'hEE);
        wait_end();
        total++; if (cap_addr.size() !== 2 || cap_addr[0] !== 32'h500 || cap_data[1] !== 32'h000000EE || cap_strb[1] !== 4'h1) $display("FAIL midreset_reload: got %0d writes want 500<-ddccbbaa, 504<-000000ee/1", cap_addr.size()); else passed++;
        total++; if (boot_done_o !== 1'b1) $display("FAIL midreset_done: got %b want 1", boot_done_o); else passed++;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_bypass();
        test_basic();
        test_partial();
        test_stalls();
        test_boundaries();
        test_errors();
        test_garbage_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
